// File: rtl/pipeline_mem_stage.sv
// EX/MEM pipeline register for the vector ASIP. Holds one instruction and
// splits vector loads/stores into MEM_W-wide beats on a narrow memory port.
module pipeline_mem_stage #(
  parameter int VEC_W  = 128,
  parameter int MEM_W  = 32,
  parameter int RA_W   = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_vf,
  input  logic              in_wmem,
  input  logic              in_rmem,
  input  logic              in_wreg,
  input  logic              in_cond_en,
  input  logic [1:0]        in_jmp_f,
  input  logic [2:0]        in_alu_ins,
  input  logic [1:0]        in_extn_sel,
  input  logic [VEC_W-1:0]  in_op_a,
  input  logic [VEC_W-1:0]  in_op_b,
  input  logic [RA_W-1:0]   in_dest,
  input  logic [RA_W-1:0]   in_src_a,
  input  logic [RA_W-1:0]   in_src_b,
  output logic              out_valid,
  output logic              out_vf,
  output logic              out_wmem,
  output logic              out_rmem,
  output logic              out_wreg,
  output logic              out_cond_en,
  output logic [1:0]        out_jmp_f,
  output logic [2:0]        out_alu_ins,
  output logic [1:0]        out_extn_sel,
  output logic [VEC_W-1:0]  out_op_a,
  output logic [VEC_W-1:0]  out_op_b,
  output logic [RA_W-1:0]   out_dest,
  output logic [RA_W-1:0]   out_src_a,
  output logic [RA_W-1:0]   out_src_b,
  output logic [VEC_W-1:0]  out_load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int BEATS = VEC_W / MEM_W;
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LDWAIT} state_e;

  state_e             state_q;
  logic [K_W-1:0]     k_q, last_q;
  logic               valid_q, vf_q, wmem_q, rmem_q, wreg_q, cond_q;
  logic [1:0]         jmp_q, extn_q;
  logic [2:0]         alu_q;
  logic [VEC_W-1:0]   op_a_q, op_b_q, ld_q;
  logic [RA_W-1:0]    dest_q, src_a_q, src_b_q;

  logic capture, in_is_mem;

  assign in_ready  = (state_q == S_IDLE) && !(valid_q && stall_in);
  assign capture   = in_valid && in_ready && !flush;
  assign in_is_mem = in_wmem | in_rmem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      vf_q    <= 1'b0;
      wmem_q  <= 1'b0;
      rmem_q  <= 1'b0;
      wreg_q  <= 1'b0;
      cond_q  <= 1'b0;
      jmp_q   <= '0;
      extn_q  <= '0;
      alu_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      ld_q    <= '0;
      dest_q  <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
    end else if (flush) begin
      // Bubble: side-effecting controls cleared, data fields left stale.
      state_q <= S_IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      wmem_q  <= 1'b0;
      rmem_q  <= 1'b0;
      cond_q  <= 1'b0;
      jmp_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (capture) begin
            vf_q    <= in_vf;
            wmem_q  <= in_wmem;
            rmem_q  <= in_rmem;
            wreg_q  <= in_wreg;
            cond_q  <= in_cond_en;
            jmp_q   <= in_jmp_f;
            extn_q  <= in_extn_sel;
            alu_q   <= in_alu_ins;
            op_a_q  <= in_op_a;
            op_b_q  <= in_op_b;
            dest_q  <= in_dest;
            src_a_q <= in_src_a;
            src_b_q <= in_src_b;
            ld_q    <= '0;
            k_q     <= '0;
            last_q  <= in_vf ? K_W'(BEATS - 1) : '0;
            if (in_is_mem) begin
              state_q <= S_ACCESS;
              valid_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
            end
          end else if (valid_q && !stall_in) begin
            valid_q <= 1'b0;
          end
        end
        S_ACCESS: begin
          // Read data lags its beat by one cycle: slot k-1 lands while beat k issues.
          if (rmem_q && (k_q != '0))
            ld_q[(int'(k_q) - 1) * MEM_W +: MEM_W] <= mem_rdata;
          if (k_q == last_q) begin
            k_q <= '0;
            if (rmem_q) begin
              state_q <= S_LDWAIT;
            end else begin
              state_q <= S_IDLE;
              valid_q <= 1'b1;
            end
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        S_LDWAIT: begin
          ld_q[int'(last_q) * MEM_W +: MEM_W] <= mem_rdata;
          state_q <= S_IDLE;
          valid_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state_q == S_ACCESS) begin
      mem_addr  = op_a_q[ADDR_W-1:0] + ADDR_W'(k_q);
      mem_wdata = op_b_q[int'(k_q) * MEM_W +: MEM_W];
      mem_we    = wmem_q;
      mem_re    = rmem_q;
    end
  end

  assign out_valid     = valid_q;
  assign out_vf        = vf_q;
  assign out_wmem      = wmem_q;
  assign out_rmem      = rmem_q;
  assign out_wreg      = wreg_q;
  assign out_cond_en   = cond_q;
  assign out_jmp_f     = jmp_q;
  assign out_alu_ins   = alu_q;
  assign out_extn_sel  = extn_q;
  assign out_op_a      = op_a_q;
  assign out_op_b      = op_b_q;
  assign out_dest      = dest_q;
  assign out_src_a     = src_a_q;
  assign out_src_b     = src_b_q;
  assign out_load_data = ld_q;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Bench for pipeline_mem_stage: pass-through vector table, beat scoreboard,
// and hand sequences for stall, flush and reset corner cases.
module tb_pipeline_mem_stage;

  localparam int VEC_W  = 128;
  localparam int MEM_W  = 32;
  localparam int RA_W   = 4;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst, flush, stall_in, in_valid, in_ready;
  logic              in_vf, in_wmem, in_rmem, in_wreg, in_cond_en;
  logic [1:0]        in_jmp_f, in_extn_sel;
  logic [2:0]        in_alu_ins;
  logic [VEC_W-1:0]  in_op_a, in_op_b;
  logic [RA_W-1:0]   in_dest, in_src_a, in_src_b;
  logic              out_valid, out_vf, out_wmem, out_rmem, out_wreg, out_cond_en;
  logic [1:0]        out_jmp_f, out_extn_sel;
  logic [2:0]        out_alu_ins;
  logic [VEC_W-1:0]  out_op_a, out_op_b, out_load_data;
  logic [RA_W-1:0]   out_dest, out_src_a, out_src_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic              mem_we, mem_re;
  logic [MEM_W-1:0]  mem_rdata = '0;

  pipeline_mem_stage #(.VEC_W(VEC_W), .MEM_W(MEM_W), .RA_W(RA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vf(in_vf), .in_wmem(in_wmem), .in_rmem(in_rmem), .in_wreg(in_wreg),
    .in_cond_en(in_cond_en), .in_jmp_f(in_jmp_f), .in_alu_ins(in_alu_ins),
    .in_extn_sel(in_extn_sel), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .in_dest(in_dest), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .out_valid(out_valid), .out_vf(out_vf), .out_wmem(out_wmem), .out_rmem(out_rmem),
    .out_wreg(out_wreg), .out_cond_en(out_cond_en), .out_jmp_f(out_jmp_f),
    .out_alu_ins(out_alu_ins), .out_extn_sel(out_extn_sel),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dest(out_dest),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_load_data(out_load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Read-only memory model: data one cycle after mem_re.
  logic [31:0] tb_mem [0:255];
  always @(posedge clk) mem_rdata <= mem_re ? tb_mem[mem_addr[7:0]] : 32'h0;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [31:0] wdata;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [2:0]   alu;
    logic [1:0]   jmp;
    logic [1:0]   extn;
    logic         cond;
    logic         wreg;
    logic [127:0] op_a;
    logic [127:0] op_b;
    logic [3:0]   dest, sa, sb;
    logic         exp_valid;
    logic         exp_ready;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    if (rst && (mem_we || mem_re)) begin
      if (mem_we) wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual addr=%h we=%b re=%b expected none", mem_addr, mem_we, mem_re);
      end else begin
        b = exp_q.pop_front();
        chk("beat_we", 128'(mem_we), 128'(b.we));
        chk("beat_re", 128'(mem_re), 128'(b.re));
        chk("beat_addr", 128'(mem_addr), 128'(b.addr));
        if (b.we) chk("beat_wdata", 128'(mem_wdata), 128'(b.wdata));
      end
    end
  end

  task automatic clr_in();
    in_valid = 0; in_vf = 0; in_wmem = 0; in_rmem = 0; in_wreg = 0; in_cond_en = 0;
    in_jmp_f = '0; in_alu_ins = '0; in_extn_sel = '0; in_op_a = '0; in_op_b = '0;
    in_dest = '0; in_src_a = '0; in_src_b = '0;
  endtask

  task automatic set_op(input logic vf, input logic wm, input logic rm, input logic wr,
                        input logic [2:0] alu, input logic [127:0] a, input logic [127:0] b);
    clr_in();
    in_valid = 1; in_vf = vf; in_wmem = wm; in_rmem = rm; in_wreg = wr;
    in_alu_ins = alu; in_op_a = a; in_op_b = b;
  endtask

  task automatic push_beats(input logic we, input logic re, input logic [15:0] addr,
                            input logic [127:0] data, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.we = we; b.re = re; b.addr = addr + 16'(i); b.wdata = data[i*32 +: 32];
      exp_q.push_back(b);
    end
  endtask

  // Counts falling edges from the drive point until out_valid, bounded.
  task automatic wait_valid(input string nm, input int exp_lat);
    int lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) in_valid = 0;
      lat++;
      if (out_valid) break;
      chk({nm, "_ready_low"}, 128'(in_ready), 128'(0));
    end
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  vec_t vt [4];

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    tb_mem[8'h80] = 32'h11; tb_mem[8'h81] = 32'h22;
    tb_mem[8'h82] = 32'h33; tb_mem[8'h83] = 32'h44;
    tb_mem[8'h85] = 32'hCAFEF00D;

    vt[0] = '{3'b010, 2'b00, 2'b01, 1'b0, 1'b1, 128'h1234, 128'h0, 4'h3, 4'h1, 4'h2, 1'b1, 1'b1};
    vt[1] = '{3'b101, 2'b10, 2'b11, 1'b1, 1'b1, 128'hFFFF_0000_1111_2222_3333_4444_5555_6666,
              128'hA5A5, 4'hF, 4'hE, 4'hD, 1'b1, 1'b1};
    vt[2] = '{3'b111, 2'b01, 2'b00, 1'b1, 1'b0, 128'h0, 128'hDEAD_BEEF, 4'h0, 4'h7, 4'h8, 1'b1, 1'b1};
    vt[3] = '{3'b000, 2'b11, 2'b10, 1'b0, 1'b1, {4{32'h89AB_CDEF}}, {4{32'h0123_4567}},
              4'h9, 4'hA, 4'hB, 1'b1, 1'b1};

    rst = 0; flush = 0; stall_in = 0;
    clr_in();
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_load_data", out_load_data, 128'(0));
    rst = 1;
    @(negedge clk);

    // Back-to-back non-memory pass-through
    for (int i = 0; i < 4; i++) begin
      clr_in();
      in_valid = 1; in_alu_ins = vt[i].alu; in_jmp_f = vt[i].jmp; in_extn_sel = vt[i].extn;
      in_cond_en = vt[i].cond; in_wreg = vt[i].wreg; in_op_a = vt[i].op_a; in_op_b = vt[i].op_b;
      in_dest = vt[i].dest; in_src_a = vt[i].sa; in_src_b = vt[i].sb;
      @(negedge clk);
      chk("alu_valid", 128'(out_valid), 128'(vt[i].exp_valid));
      chk("alu_ready", 128'(in_ready), 128'(vt[i].exp_ready));
      chk("alu_ins", 128'(out_alu_ins), 128'(vt[i].alu));
      chk("alu_ctl", 128'({out_jmp_f, out_extn_sel, out_cond_en, out_wreg, out_wmem, out_rmem}),
          128'({vt[i].jmp, vt[i].extn, vt[i].cond, vt[i].wreg, 2'b00}));
      chk("alu_op_a", out_op_a, vt[i].op_a);
      chk("alu_op_b", out_op_b, vt[i].op_b);
      chk("alu_regs", 128'({out_dest, out_src_a, out_src_b}), 128'({vt[i].dest, vt[i].sa, vt[i].sb}));
    end
    clr_in();
    @(negedge clk);
    chk("alu_valid_drop", 128'(out_valid), 128'(0));

    // Vector store
    set_op(1, 1, 0, 0, 3'b000, 128'h40, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    push_beats(1, 0, 16'h0040, in_op_b, 4);
    wait_valid("vst", 5);
    chk("vst_out_wmem", 128'(out_wmem), 128'(1));

    // Vector load
    set_op(1, 0, 1, 1, 3'b000, 128'h80, 128'h0);
    push_beats(0, 1, 16'h0080, 128'h0, 4);
    wait_valid("vld", 6);
    chk("vld_data", out_load_data, 128'h00000044_00000033_00000022_00000011);

    // Scalar load, upper bits must be cleared
    set_op(0, 0, 1, 1, 3'b000, 128'h85, 128'h0);
    push_beats(0, 1, 16'h0085, 128'h0, 1);
    wait_valid("sld", 3);
    chk("sld_data", out_load_data, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D);

    // Scalar store and address wrap on a vector store
    set_op(0, 1, 0, 0, 3'b000, 128'h1234, 128'h9999_8888_7777_6666);
    push_beats(1, 0, 16'h1234, in_op_b, 1);
    wait_valid("sst", 2);
    set_op(1, 1, 0, 0, 3'b000, 128'hFFFE, 128'h44444444_33333333_22222222_11111111);
    push_beats(1, 0, 16'hFFFE, in_op_b, 4);
    wait_valid("wrap", 5);

    // Stall holds outputs and blocks capture
    set_op(0, 0, 0, 1, 3'b011, 128'h5555, 128'h0);
    @(negedge clk);
    chk("stl_valid0", 128'(out_valid), 128'(1));
    stall_in = 1;
    set_op(0, 0, 0, 1, 3'b110, 128'h7777, 128'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stl_hold_valid", 128'(out_valid), 128'(1));
      chk("stl_hold_op_a", out_op_a, 128'h5555);
      chk("stl_hold_alu", 128'(out_alu_ins), 128'(3'b011));
      chk("stl_ready", 128'(in_ready), 128'(0));
    end
    stall_in = 0;
    @(negedge clk);
    chk("stl_cap_op_a", out_op_a, 128'h7777);
    chk("stl_cap_valid", 128'(out_valid), 128'(1));
    clr_in();
    @(negedge clk);

    // Flush after beat 1 of a vector store
    w0 = wr_cnt;
    set_op(1, 1, 0, 1, 3'b000, 128'h40, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    push_beats(1, 0, 16'h0040, in_op_b, 2);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_wreg_wmem", 128'({out_wreg, out_wmem}), 128'(0));
    chk("fl_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    chk("fl_writes", 128'(wr_cnt - w0), 128'(2));

    // Flush together with in_valid: nothing captured
    set_op(0, 0, 0, 1, 3'b001, 128'hABCD, 128'h0);
    flush = 1;
    @(negedge clk);
    flush = 0; clr_in();
    chk("flin_valid", 128'(out_valid), 128'(0));
    chk("flin_wreg", 128'(out_wreg), 128'(0));

    // Flush wins over stall
    set_op(0, 0, 0, 1, 3'b001, 128'h1111, 128'h0);
    @(negedge clk);
    clr_in();
    stall_in = 1; flush = 1;
    @(negedge clk);
    stall_in = 0; flush = 0;
    chk("flst_valid", 128'(out_valid), 128'(0));

    // Asynchronous reset in the middle of a vector store
    set_op(1, 1, 0, 1, 3'b000, 128'h10, {4{32'h5A5A_0F0F}});
    push_beats(1, 0, 16'h0010, in_op_b, 2);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("arst_mem_we", 128'(mem_we), 128'(0));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_op_b", out_op_b, 128'(0));
    chk("arst_mem_addr", 128'(mem_addr), 128'(0));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("arst_idle_ready", 128'(in_ready), 128'(1));
    chk("arst_idle_we", 128'(mem_we), 128'(0));

    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
